// File: rtl/subckt_stim_resp.sv
// Stimulus/response engine for extracted single-output subcircuits: a Galois LFSR drives the
// subcircuit inputs, and a MISR compacts its output, delayed by LAT, into a pass/fail signature.
module subckt_stim_resp #(
  parameter int                IN_W         = 3,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] POLY         = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
  parameter int                NUM_PATTERNS = 1000,
  parameter int                LAT          = 2
) (
  input  logic                                 I1470_clk,
  input  logic                                 I1477_rst,
  input  logic                                 start,
  input  logic [LFSR_W-1:0]                    golden_sig,
  input  logic                                 resp_in,
  output logic [IN_W-1:0]                      stim_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic [LFSR_W-1:0]                    signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]    pat_cnt
);

  localparam int              CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] misr;
  logic [LAT-1:0]    tok_vld;
  logic              arm;
  logic              tok_out;
  logic              tok_empty;

  function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] x);
    return (x >> 1) ^ (x[0] ? POLY : '0);
  endfunction

  function automatic logic [LFSR_W-1:0] compact(input logic [LFSR_W-1:0] m, input logic r);
    return step(m) ^ {{(LFSR_W-1){1'b0}}, r};
  endfunction

  assign arm       = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign tok_out   = tok_vld[LAT-1];
  assign tok_empty = (tok_vld == '0);

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)               state_nxt = S_RUN;
      S_RUN:   if (pat_cnt == LAST_CNT) state_nxt = S_DRAIN;
      S_DRAIN: if (tok_empty)           state_nxt = S_DONE;
      S_DONE:  if (start)               state_nxt = S_RUN;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // Each applied pattern launches a token; the response is compacted when its token
  // falls out of the LAT-deep shift register, aligning it with the subcircuit pipeline.
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      lfsr    <= SEED;
      misr    <= '0;
      pat_cnt <= '0;
      pass    <= 1'b0;
      tok_vld <= '0;
    end else if (arm) begin
      lfsr    <= SEED;
      misr    <= '0;
      pat_cnt <= '0;
      pass    <= 1'b0;
      tok_vld <= '0;
    end else begin
      if (state == S_RUN) begin
        lfsr    <= step(lfsr);
        pat_cnt <= pat_cnt + CNT_W'(1);
      end
      if ((state == S_RUN) || (state == S_DRAIN))
        tok_vld <= (tok_vld << 1) | LAT'(state == S_RUN);
      if (tok_out)
        misr <= compact(misr, resp_in);
      if ((state == S_DRAIN) && tok_empty)
        pass <= (misr == golden_sig);
    end
  end

  // Outputs decode registered state only, so stim_out is 0 outside RUN.
  assign stim_out  = (state == S_RUN) ? lfsr[IN_W-1:0] : '0;
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign signature = misr;

endmodule
